uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: maximum data bits per frame (5..16).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6: width of Prescale.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: CLK  in  1  clock; RST  in  1  reset.
REQ-005 SHALL have port RX_IN  in  1  serial line, idle high.
REQ-006 SHALL have port Prescale  in  PRESCALE_WIDTH  oversampling clocks per bit; values <4 are treated as 4.
REQ-007 SHALL have port DATA_LEN  in  5  data bits per frame; values outside 5..DATA_WIDTH are treated as DATA_WIDTH.
REQ-008 SHALL have port PAR_EN  in  1  parity bit present.
REQ-009 SHALL have port PAR_TYP  in  1  0 = even, 1 = odd.
REQ-010 SHALL have port STOP2  in  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port RD_EN  in  1  pop FIFO head.
REQ-012 SHALL have port P_DATA  out  DATA_WIDTH  head data, right-aligned, unused MSBs 0.
REQ-013 SHALL have ports par_err and stp_err  out  1 each  error flags of the head entry.
REQ-014 SHALL have port data_valid  out  1  FIFO not empty.
REQ-015 SHALL have ports fifo_full, overrun and brk_det  out  1 each  FIFO full; one-cycle frame-dropped pulse; one-cycle break pulse.

Function
REQ-016 SHALL pass RX_IN through a 2-flop synchroniser; all timing below refers to the synchronised line.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-018 SHALL move IDLE->START on a low synchronised line and latch Prescale, DATA_LEN, PAR_EN, PAR_TYP and STOP2 in that cycle; input changes mid-frame SHALL be ignored.
REQ-019 SHALL run an edge counter 0..P-1 per bit (P = latched prescale), starting at 0 in the first START cycle, and advance the bit on wrap.
REQ-020 SHALL form each bit by majority of 3 samples at edge counts P/2-1, P/2 and P/2+1, with P/2 floored.
REQ-021 SHALL return START->IDLE with no frame and no flags if the start-bit majority is 1 (glitch).
REQ-022 SHALL receive DATA LSB first for DATA_LEN bits, then go to PARITY if PAR_EN, else to STOP.
REQ-023 SHALL set par_err when XOR(data bits, parity bit) is 1 for even parity or 0 for odd parity; par_err SHALL be 0 when PAR_EN = 0.
REQ-024 SHALL sample 1 or 2 stop bits; stp_err SHALL be 1 if any stop-bit majority is 0.
REQ-025 SHALL push {data, par_err, stp_err} one cycle after the final stop-bit sample at edge P/2+1, and SHALL then enter IDLE at once without waiting for the end of the bit.
REQ-026 SHALL treat a frame whose data, parity and stop majorities are all 0 as a break: no push, brk_det pulses one cycle, and the FSM enters BREAK_WAIT until the line reads 1, then IDLE.
REQ-027 SHALL drive P_DATA, par_err and stp_err combinationally from the FIFO head entry.
REQ-028 SHALL pop on RD_EN && data_valid, with the new head visible on the next cycle; RD_EN SHALL be ignored when empty.
REQ-029 SHALL drop a frame pushed while full and without a same-cycle pop, pulse overrun for one cycle, and leave FIFO contents unchanged.
REQ-030 SHALL perform both operations on a simultaneous push and pop when full, with no overrun; a push to an empty FIFO SHALL raise data_valid on the next cycle.
REQ-031 SHALL use pointers of log2(FIFO_DEPTH)+1 bits, with full/empty decided by the MSB compare and wrap-around free of corruption.

Reset
REQ-032 SHALL on RST place the FSM in IDLE, clear the counters and FIFO pointers, set the synchroniser flops to 1, and drive every output to 0.
REQ-033 SHALL on RST mid-frame discard the partial frame, with no push and no flag.

Verification
REQ-034 Bench SHALL check: Prescale = 8, 8N1, byte 0xA5 -> one entry P_DATA = 0xA5, par_err = 0, stp_err = 0, data_valid high.
REQ-035 Bench SHALL check: DATA_LEN = 7, PAR_EN = 1, PAR_TYP = 0, STOP2 = 1, data 0x55 with parity bit 1 -> P_DATA = 0x055, par_err = 1; second stop bit 0 -> stp_err = 1.
REQ-036 Bench SHALL check: Prescale = 16, RX_IN low for 3 cycles -> no entry, FSM back in IDLE, no flag.
REQ-037 Bench SHALL check: line low for 12 bit times, 8N1 -> brk_det one pulse, no entry, next frame 0x3C received correctly after the line returns high.
REQ-038 Bench SHALL check: FIFO_DEPTH = 4, frames 0x01..0x05 with no reads -> fifo_full after the 4th, overrun pulse on the 5th, reads return 0x01..0x04, then data_valid = 0.
REQ-039 Bench SHALL check: RST asserted during the data bits -> all outputs 0, and the following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ext
//  Purpose  : Oversampling UART receiver with runtime frame format, break
//             detection and a small receive FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ext #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [4:0]                DATA_LEN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic                      RD_EN,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      data_valid,
    output logic                      fifo_full,
    output logic                      overrun,
    output logic                      brk_det
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_EW = DATA_WIDTH + 2;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_START      = 3'd1;
    localparam logic [2:0] c_DATA       = 3'd2;
    localparam logic [2:0] c_PARITY     = 3'd3;
    localparam logic [2:0] c_STOP       = 3'd4;
    localparam logic [2:0] c_BREAK_WAIT = 3'd5;

    // ------------------------------------------------------------------
    // Line synchroniser (idle-high, so flops reset to 1)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [4:0]                r_len;
    logic [4:0]                r_bit;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic                      r_stop2;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par_acc;
    logic                      r_par_bit;
    logic                      r_all_zero;
    logic                      r_stp_bad;
    logic                      r_smp_a;
    logic                      r_smp_b;
    logic                      r_push;
    logic [c_EW-1:0]           r_push_word;
    logic                      r_brk;

    logic [PRESCALE_WIDTH-1:0] w_presc_eff;
    logic [4:0]                w_len_eff;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic                      w_wrap;
    logic                      w_s0;
    logic                      w_s1;
    logic                      w_s2;
    logic                      w_maj;
    logic                      w_last_stop;
    logic                      w_par_err;
    logic [DATA_WIDTH-1:0]     w_data_aligned;

    assign w_presc_eff = (Prescale < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : Prescale;
    assign w_len_eff   = (DATA_LEN < 5'd5 || DATA_LEN > 5'(DATA_WIDTH)) ? 5'(DATA_WIDTH) : DATA_LEN;

    assign w_half = r_presc >> 1;
    assign w_wrap = (r_cnt == r_presc - PRESCALE_WIDTH'(1));
    assign w_s0   = (r_cnt == w_half - PRESCALE_WIDTH'(1));
    assign w_s1   = (r_cnt == w_half);
    assign w_s2   = (r_cnt == w_half + PRESCALE_WIDTH'(1));
    assign w_maj  = (r_smp_a & r_smp_b) | (r_smp_a & w_rx) | (r_smp_b & w_rx);

    assign w_last_stop    = !r_stop2 || (r_bit == 5'd1);
    assign w_par_err      = r_par_en & (r_par_acc ^ r_par_bit ^ r_par_typ);
    // Data arrives LSB first into the top of the shift register; short frames
    // must be shifted down to be right-aligned.
    assign w_data_aligned = r_shift >> (5'(DATA_WIDTH) - r_len);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_presc     <= '0;
            r_len       <= '0;
            r_bit       <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_stop2     <= 1'b0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_bit   <= 1'b0;
            r_all_zero  <= 1'b0;
            r_stp_bad   <= 1'b0;
            r_smp_a     <= 1'b0;
            r_smp_b     <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_brk       <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_brk  <= 1'b0;

            if (r_state != c_IDLE && r_state != c_BREAK_WAIT) begin
                r_cnt <= w_wrap ? '0 : r_cnt + PRESCALE_WIDTH'(1);
                if (w_s0) r_smp_a <= w_rx;
                if (w_s1) r_smp_b <= w_rx;
            end

            case (r_state)
                c_IDLE: begin
                    if (!w_rx) begin
                        r_state    <= c_START;
                        r_cnt      <= '0;
                        r_presc    <= w_presc_eff;
                        r_len      <= w_len_eff;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_stop2    <= STOP2;
                        r_bit      <= '0;
                        r_par_acc  <= 1'b0;
                        r_par_bit  <= 1'b0;
                        r_all_zero <= 1'b1;
                        r_stp_bad  <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_s2 && w_maj)
                        r_state <= c_IDLE;
                    else if (w_wrap)
                        r_state <= c_DATA;
                end
                c_DATA: begin
                    if (w_s2) begin
                        r_shift    <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                        r_par_acc  <= r_par_acc ^ w_maj;
                        r_all_zero <= r_all_zero & ~w_maj;
                    end
                    if (w_wrap) begin
                        if (r_bit == r_len - 5'd1) begin
                            r_bit   <= '0;
                            r_state <= r_par_en ? c_PARITY : c_STOP;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end
                end
                c_PARITY: begin
                    if (w_s2) begin
                        r_par_bit  <= w_maj;
                        r_all_zero <= r_all_zero & ~w_maj;
                    end
                    if (w_wrap)
                        r_state <= c_STOP;
                end
                c_STOP: begin
                    if (w_wrap)
                        r_bit <= 5'd1;
                    // The frame completes at the final stop sample, not at the
                    // end of the bit, so back-to-back frames resync early.
                    if (w_s2) begin
                        if (w_last_stop) begin
                            if (r_all_zero && !w_maj) begin
                                r_brk   <= 1'b1;
                                r_state <= c_BREAK_WAIT;
                            end else begin
                                r_push      <= 1'b1;
                                r_push_word <= {w_data_aligned, w_par_err, r_stp_bad | ~w_maj};
                                r_state     <= c_IDLE;
                            end
                        end else begin
                            r_stp_bad  <= r_stp_bad | ~w_maj;
                            r_all_zero <= r_all_zero & ~w_maj;
                        end
                    end
                end
                c_BREAK_WAIT: begin
                    if (w_rx)
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wp;
    logic [c_AW:0]   r_rp;
    logic            r_overrun;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [c_EW-1:0] w_head;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
    assign w_pop   = RD_EN && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push && w_full && !w_pop;
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr)
            r_mem[r_wp[c_AW-1:0]] <= r_push_word;
    end

    // Head entry is masked while empty so stale storage never leaks out.
    assign w_head     = w_empty ? '0 : r_mem[r_rp[c_AW-1:0]];
    assign P_DATA     = w_head[c_EW-1:2];
    assign par_err    = w_head[1];
    assign stp_err    = w_head[0];
    assign data_valid = !w_empty;
    assign fifo_full  = w_full;
    assign overrun    = r_overrun;
    assign brk_det    = r_brk;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ext
//  Purpose  : Directed, table-driven bench for uart_rx_ext.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

    localparam int c_DW = 8;
    localparam int c_PW = 6;
    localparam int c_FD = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic            RX_IN;
    logic [c_PW-1:0] Prescale;
    logic [4:0]      DATA_LEN;
    logic            PAR_EN;
    logic            PAR_TYP;
    logic            STOP2;
    logic            RD_EN;
    logic [c_DW-1:0] P_DATA;
    logic            par_err;
    logic            stp_err;
    logic            data_valid;
    logic            fifo_full;
    logic            overrun;
    logic            brk_det;

    uart_rx_ext #(
        .DATA_WIDTH    (c_DW),
        .PRESCALE_WIDTH(c_PW),
        .FIFO_DEPTH    (c_FD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .Prescale  (Prescale),
        .DATA_LEN  (DATA_LEN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .RD_EN     (RD_EN),
        .P_DATA    (P_DATA),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .data_valid(data_valid),
        .fifo_full (fifo_full),
        .overrun   (overrun),
        .brk_det   (brk_det)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int brk_cnt  = 0;
    int ovr_cnt  = 0;

    // Count cycles each pulse output is high; a clean pulse adds exactly one.
    always @(negedge CLK) begin
        if (brk_det) brk_cnt <= brk_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    typedef struct {
        int presc_in;   // value driven on Prescale
        int bitp;       // effective clocks per bit
        int len_in;     // value driven on DATA_LEN
        int nbits;      // effective data bits sent
        bit pe;
        bit pt;
        bit s2;
        int data;
        bit pbit;
        bit st1v;
        bit st2v;
        int exp_data;
        bit exp_pe;
        bit exp_se;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input bit b, input int p);
        RX_IN = b;
        cyc(p);
    endtask

    task automatic send_frame(input int p, input int nbits, input int data, input bit pe,
                              input bit pbit, input bit s2, input bit st1, input bit st2);
        send_bit(1'b0, p);
        for (int i = 0; i < nbits; i++)
            send_bit(data[i], p);
        if (pe) send_bit(pbit, p);
        send_bit(st1, p);
        if (s2) send_bit(st2, p);
        RX_IN = 1'b1;
    endtask

    task automatic set_cfg(input int presc, input int len, input bit pe, input bit pt, input bit s2);
        Prescale = c_PW'(presc);
        DATA_LEN = 5'(len);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
    endtask

    task automatic send_8n1(input int data);
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8, data, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(20);
    endtask

    task automatic pop();
        RD_EN = 1'b1;
        cyc(1);
        RD_EN = 1'b0;
        cyc(1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pdata"}, int'(P_DATA), 0);
        chk({tag, "_par"}, int'(par_err), 0);
        chk({tag, "_stp"}, int'(stp_err), 0);
        chk({tag, "_valid"}, int'(data_valid), 0);
        chk({tag, "_full"}, int'(fifo_full), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
        chk({tag, "_brk"}, int'(brk_det), 0);
    endtask

    initial begin
        int b0;
        int o0;

        //           presc bitp len nb pe pt s2 data  pb st1 st2 exp   pe se
        vecs[0] = '{ 8,    8,   8,  8, 0, 0, 0, 'hA5, 0, 1,  1,  'hA5, 0, 0};
        vecs[1] = '{ 8,    8,   7,  7, 1, 0, 1, 'h55, 1, 1,  0,  'h55, 1, 1};
        vecs[2] = '{ 2,    4,   5,  5, 1, 1, 0, 'h13, 0, 1,  1,  'h13, 0, 0};
        vecs[3] = '{ 16,   16,  3,  8, 1, 0, 0, 'hC3, 0, 1,  1,  'hC3, 0, 0};
        vecs[4] = '{ 10,   10,  6,  6, 1, 0, 0, 'h2A, 0, 1,  1,  'h2A, 1, 0};
        vecs[5] = '{ 5,    5,   8,  8, 0, 0, 0, 'h7E, 0, 0,  1,  'h7E, 0, 1};
        vecs[6] = '{ 7,    7,   8,  8, 1, 1, 1, 'h00, 1, 1,  1,  'h00, 0, 0};
        vecs[7] = '{ 6,    6,   16, 8, 0, 0, 1, 'h0F, 0, 1,  1,  'h0F, 0, 0};

        RST   = 1'b1;
        RX_IN = 1'b1;
        RD_EN = 1'b0;
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        cyc(3);
        chk_all_zero("reset");
        RST = 1'b0;
        cyc(5);

        // Table-driven frame formats
        for (int i = 0; i < 8; i++) begin
            set_cfg(vecs[i].presc_in, vecs[i].len_in, vecs[i].pe, vecs[i].pt, vecs[i].s2);
            send_frame(vecs[i].bitp, vecs[i].nbits, vecs[i].data, vecs[i].pe,
                       vecs[i].pbit, vecs[i].s2, vecs[i].st1v, vecs[i].st2v);
            cyc(20);
            chk($sformatf("v%0d_valid", i), int'(data_valid), 1);
            chk($sformatf("v%0d_data", i), int'(P_DATA), vecs[i].exp_data);
            chk($sformatf("v%0d_par", i), int'(par_err), int'(vecs[i].exp_pe));
            chk($sformatf("v%0d_stp", i), int'(stp_err), int'(vecs[i].exp_se));
            pop();
            chk($sformatf("v%0d_empty", i), int'(data_valid), 0);
        end
        chk("tbl_brk", brk_cnt, 0);
        chk("tbl_ovr", ovr_cnt, 0);

        // Start-bit glitch
        set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b0;
        cyc(3);
        RX_IN = 1'b1;
        cyc(40);
        chk("glitch_valid", int'(data_valid), 0);
        chk("glitch_brk", brk_cnt, 0);
        send_8n1('h5A);
        chk("glitch_next", int'(P_DATA), 'h5A);
        chk("glitch_next_valid", int'(data_valid), 1);
        pop();

        // Break condition
        b0 = brk_cnt;
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b0;
        cyc(96);
        chk("brk_pulse", brk_cnt - b0, 1);
        chk("brk_valid", int'(data_valid), 0);
        RX_IN = 1'b1;
        cyc(20);
        chk("brk_single", brk_cnt - b0, 1);
        send_8n1('h3C);
        chk("brk_next_valid", int'(data_valid), 1);
        chk("brk_next_data", int'(P_DATA), 'h3C);
        chk("brk_next_stp", int'(stp_err), 0);
        pop();

        // FIFO fill and overrun
        o0 = ovr_cnt;
        for (int k = 1; k <= 4; k++) begin
            send_8n1(k);
            chk($sformatf("fill%0d_full", k), int'(fifo_full), (k == 4) ? 1 : 0);
        end
        chk("fill_no_ovr", ovr_cnt - o0, 0);
        send_8n1(5);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        chk("ovr_full", int'(fifo_full), 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("rd%0d_data", k), int'(P_DATA), k);
            chk($sformatf("rd%0d_valid", k), int'(data_valid), 1);
            pop();
        end
        chk("drain_valid", int'(data_valid), 0);
        chk("drain_full", int'(fifo_full), 0);
        pop();
        send_8n1('h66);
        chk("after_empty_rd", int'(P_DATA), 'h66);
        chk("after_empty_cnt", int'(data_valid), 1);
        pop();
        chk("after_empty_pop", int'(data_valid), 0);

        // Reset during data bits
        send_8n1('h99);
        chk("pre_rst_valid", int'(data_valid), 1);
        b0 = brk_cnt;
        o0 = ovr_cnt;
        set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        RST   = 1'b1;
        RX_IN = 1'b1;
        cyc(1);
        chk_all_zero("midrst");
        RST = 1'b0;
        cyc(40);
        chk("midrst_after_valid", int'(data_valid), 0);
        chk("midrst_flags", (brk_cnt - b0) + (ovr_cnt - o0), 0);
        send_8n1('h81);
        chk("midrst_next_valid", int'(data_valid), 1);
        chk("midrst_next_data", int'(P_DATA), 'h81);
        chk("midrst_next_err", int'({par_err, stp_err}), 0);
        pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
